// File: rtl/half_duplex_ctrl.sv
// Half-duplex line controller: buffers outbound words, owns bus direction and
// inserts dead turnaround cycles between transmit and receive.
module half_duplex_ctrl #(
    parameter int WIDTH     = 8,
    parameter int DEPTH     = 4,
    parameter int TA_CYCLES = 2
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             tx_valid,
    input  logic [WIDTH-1:0] tx_data,
    output logic             tx_ready,
    output logic             rx_valid,
    output logic [WIDTH-1:0] rx_data,
    output logic             line_dir,
    output logic [WIDTH-1:0] line_out,
    output logic             line_out_valid,
    input  logic [WIDTH-1:0] line_in,
    input  logic             line_in_valid,
    output logic             busy
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;
    localparam int TW = $clog2(TA_CYCLES + 1);
    localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);
    localparam logic [TW-1:0] TA_C    = TW'(TA_CYCLES);

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_TURN_TX = 2'd1,
        ST_SEND    = 2'd2,
        ST_TURN_RX = 2'd3
    } state_t;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [PW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [PW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]    count_q, count_d;
    logic [TW-1:0]    ta_cnt_q, ta_cnt_d;
    logic             rx_valid_q, rx_valid_d;
    logic [WIDTH-1:0] rx_data_q, rx_data_d;
    logic [WIDTH-1:0] last_out_q, last_out_d;
    logic             full_s, push_s, pop_s;
    logic [WIDTH-1:0] head_s;

    // FIFO handshake decode from registered occupancy and state
    always_comb begin
        full_s = (count_q == DEPTH_C);
        push_s = tx_valid && !full_s;
        pop_s  = (state_q == ST_SEND) && (count_q != {CW{1'b0}});
        head_s = mem_q[rd_ptr_q];
    end

    // Direction / turnaround state machine and receive capture
    always_comb begin
        state_d    = state_q;
        ta_cnt_d   = ta_cnt_q;
        rx_valid_d = 1'b0;
        rx_data_d  = rx_data_q;
        case (state_q)
            ST_IDLE: begin
                // Receive wins; a pending transmit waits until the remote goes quiet
                if (line_in_valid) begin
                    rx_valid_d = 1'b1;
                    rx_data_d  = line_in;
                end else if ((count_q != {CW{1'b0}}) || push_s) begin
                    state_d  = ST_TURN_TX;
                    ta_cnt_d = TA_C;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_TURN_TX: begin
                if (ta_cnt_q == TW'(1)) begin
                    state_d = ST_SEND;
                end else begin
                    ta_cnt_d = ta_cnt_q - TW'(1);
                end
            end
            ST_SEND: begin
                if ((count_q == CW'(1)) && !push_s) begin
                    state_d  = ST_TURN_RX;
                    ta_cnt_d = TA_C;
                end else begin
                    state_d = ST_SEND;
                end
            end
            ST_TURN_RX: begin
                if (ta_cnt_q == TW'(1)) begin
                    state_d = ST_IDLE;
                end else begin
                    ta_cnt_d = ta_cnt_q - TW'(1);
                end
            end
            default: begin
                state_d  = ST_IDLE;
                ta_cnt_d = {TW{1'b0}};
            end
        endcase
    end

    // FIFO pointer, occupancy and held line_out value
    always_comb begin
        wr_ptr_d   = push_s ? (wr_ptr_q + PW'(1)) : wr_ptr_q;
        rd_ptr_d   = pop_s ? (rd_ptr_q + PW'(1)) : rd_ptr_q;
        last_out_d = pop_s ? head_s : last_out_q;
        case ({push_s, pop_s})
            2'b10:   count_d = count_q + CW'(1);
            2'b01:   count_d = count_q - CW'(1);
            default: count_d = count_q;
        endcase
    end

    // Storage array; pointers carry validity so no reset is needed here
    always_ff @(posedge clk) begin
        if (push_s) begin
            mem_q[wr_ptr_q] <= tx_data;
        end
    end

    // State and control registers with synchronous reset
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q    <= ST_IDLE;
            wr_ptr_q   <= {PW{1'b0}};
            rd_ptr_q   <= {PW{1'b0}};
            count_q    <= {CW{1'b0}};
            ta_cnt_q   <= {TW{1'b0}};
            rx_valid_q <= 1'b0;
            rx_data_q  <= {WIDTH{1'b0}};
            last_out_q <= {WIDTH{1'b0}};
        end else begin
            state_q    <= state_d;
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            count_q    <= count_d;
            ta_cnt_q   <= ta_cnt_d;
            rx_valid_q <= rx_valid_d;
            rx_data_q  <= rx_data_d;
            last_out_q <= last_out_d;
        end
    end

    assign tx_ready       = !full_s;
    assign busy           = (state_q != ST_IDLE);
    assign line_dir       = (state_q == ST_TURN_TX) || (state_q == ST_SEND);
    assign line_out_valid = (state_q == ST_SEND);
    assign line_out       = (state_q == ST_SEND) ? head_s : last_out_q;
    assign rx_valid       = rx_valid_q;
    assign rx_data        = rx_data_q;

endmodule

// File: tb/tb_half_duplex_ctrl.sv
// Table-driven bench for half_duplex_ctrl; transmitted words are tracked by a
// scoreboard queue filled on accepted pushes and drained on line_out_valid.
module tb_half_duplex_ctrl;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       tx_valid = 1'b0;
    logic [7:0] tx_data = 8'h00;
    logic       tx_ready;
    logic       rx_valid;
    logic [7:0] rx_data;
    logic       line_dir;
    logic [7:0] line_out;
    logic       line_out_valid;
    logic [7:0] line_in = 8'h00;
    logic       line_in_valid = 1'b0;
    logic       busy;

    int n_checks = 0;
    int n_fail   = 0;
    logic [7:0] exp_q [$];

    half_duplex_ctrl #(.WIDTH(8), .DEPTH(4), .TA_CYCLES(2)) dut (
        .clk(clk), .rst_n(rst_n),
        .tx_valid(tx_valid), .tx_data(tx_data), .tx_ready(tx_ready),
        .rx_valid(rx_valid), .rx_data(rx_data),
        .line_dir(line_dir), .line_out(line_out), .line_out_valid(line_out_valid),
        .line_in(line_in), .line_in_valid(line_in_valid), .busy(busy)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic       rst_n;
        logic       tv;
        logic [7:0] td;
        logic       liv;
        logic [7:0] li;
        logic       e_dir;
        logic       e_lov;
        logic       e_rxv;
        logic [7:0] e_rxd;
        logic       e_busy;
        logic       e_rdy;
        bit         chk;
    } vec_t;

    vec_t vecs [$];

    function automatic vec_t mk(input logic r, input logic tv, input logic [7:0] td,
                                input logic liv, input logic [7:0] li,
                                input logic dir, input logic lov, input logic rxv,
                                input logic [7:0] rxd, input logic bsy, input logic rdy,
                                input bit chk);
        vec_t v;
        v.rst_n = r; v.tv = tv; v.td = td; v.liv = liv; v.li = li;
        v.e_dir = dir; v.e_lov = lov; v.e_rxv = rxv; v.e_rxd = rxd;
        v.e_busy = bsy; v.e_rdy = rdy; v.chk = chk;
        return v;
    endfunction

    task automatic check(input string tag, input string name, input logic [7:0] got,
                         input logic [7:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s %s: got %02h, required %02h", tag, name, got, exp);
        end
    endtask

    // One cycle: drive inputs at the falling edge, check registered outputs there
    task automatic apply(input vec_t v, input string tag);
        logic [7:0] w;
        @(negedge clk);
        rst_n         = v.rst_n;
        tx_valid      = v.tv;
        tx_data       = v.td;
        line_in_valid = v.liv;
        line_in       = v.li;
        if (v.chk) begin
            check(tag, "line_dir", {7'd0, line_dir}, {7'd0, v.e_dir});
            check(tag, "line_out_valid", {7'd0, line_out_valid}, {7'd0, v.e_lov});
            check(tag, "rx_valid", {7'd0, rx_valid}, {7'd0, v.e_rxv});
            check(tag, "rx_data", rx_data, v.e_rxd);
            check(tag, "busy", {7'd0, busy}, {7'd0, v.e_busy});
            check(tag, "tx_ready", {7'd0, tx_ready}, {7'd0, v.e_rdy});
        end
        if (line_out_valid === 1'b1) begin
            n_checks++;
            if (exp_q.size() == 0) begin
                n_fail++;
                $display("FAIL %s line_out: got word %02h, required no word", tag, line_out);
            end else begin
                w = exp_q.pop_front();
                if (line_out !== w) begin
                    n_fail++;
                    $display("FAIL %s line_out: got %02h, required %02h", tag, line_out, w);
                end
            end
        end
        if (!v.rst_n) begin
            exp_q.delete();
        end else if (v.tv && v.e_rdy) begin
            exp_q.push_back(v.td);
        end
    endtask

    initial begin
        // Reset held two cycles with inputs active
        vecs.push_back(mk(0,1,8'hAA,1,8'h55, 0,0,0,8'h00,0,1,0));
        vecs.push_back(mk(0,1,8'hAA,1,8'h55, 0,0,0,8'h00,0,1,1));
        vecs.push_back(mk(1,0,8'h00,0,8'h00, 0,0,0,8'h00,0,1,1));
        vecs.push_back(mk(1,0,8'h00,0,8'h00, 0,0,0,8'h00,0,1,1));
        // Single word: two TURN_TX, one SEND, two TURN_RX
        vecs.push_back(mk(1,1,8'hA5,0,8'h00, 0,0,0,8'h00,0,1,1));
        vecs.push_back(mk(1,0,8'h00,0,8'h00, 1,0,0,8'h00,1,1,1));
        vecs.push_back(mk(1,0,8'h00,0,8'h00, 1,0,0,8'h00,1,1,1));
        vecs.push_back(mk(1,0,8'h00,0,8'h00, 1,1,0,8'h00,1,1,1));
        vecs.push_back(mk(1,0,8'h00,0,8'h00, 0,0,0,8'h00,1,1,1));
        vecs.push_back(mk(1,0,8'h00,0,8'h00, 0,0,0,8'h00,1,1,1));
        vecs.push_back(mk(1,0,8'h00,0,8'h00, 0,0,0,8'h00,0,1,1));
        // Receive, then receive+push in the same cycle, with guard strobes
        vecs.push_back(mk(1,0,8'h00,1,8'h3C, 0,0,0,8'h00,0,1,1));
        vecs.push_back(mk(1,0,8'h00,0,8'h00, 0,0,1,8'h3C,0,1,1));
        vecs.push_back(mk(1,0,8'h00,0,8'h00, 0,0,0,8'h3C,0,1,1));
        vecs.push_back(mk(1,1,8'h77,1,8'h5A, 0,0,0,8'h3C,0,1,1));
        vecs.push_back(mk(1,0,8'h00,0,8'h00, 0,0,1,8'h5A,0,1,1));
        vecs.push_back(mk(1,0,8'h00,1,8'hFF, 1,0,0,8'h5A,1,1,1));
        vecs.push_back(mk(1,0,8'h00,1,8'hFF, 1,0,0,8'h5A,1,1,1));
        vecs.push_back(mk(1,0,8'h00,0,8'h00, 1,1,0,8'h5A,1,1,1));
        vecs.push_back(mk(1,0,8'h00,1,8'hFF, 0,0,0,8'h5A,1,1,1));
        vecs.push_back(mk(1,0,8'h00,1,8'hFF, 0,0,0,8'h5A,1,1,1));
        vecs.push_back(mk(1,0,8'h00,0,8'h00, 0,0,0,8'h5A,0,1,1));
        vecs.push_back(mk(1,0,8'h00,0,8'h00, 0,0,0,8'h5A,0,1,1));
        // Fill FIFO while receiving holds IDLE; fifth word dropped
        vecs.push_back(mk(1,1,8'h01,1,8'hB1, 0,0,0,8'h5A,0,1,1));
        vecs.push_back(mk(1,1,8'h02,1,8'hB2, 0,0,1,8'hB1,0,1,1));
        vecs.push_back(mk(1,1,8'h03,1,8'hB3, 0,0,1,8'hB2,0,1,1));
        vecs.push_back(mk(1,1,8'h04,1,8'hB4, 0,0,1,8'hB3,0,1,1));
        vecs.push_back(mk(1,1,8'h05,1,8'hB5, 0,0,1,8'hB4,0,0,1));
        vecs.push_back(mk(1,0,8'h00,0,8'h00, 0,0,1,8'hB5,0,0,1));
        vecs.push_back(mk(1,0,8'h00,0,8'h00, 1,0,0,8'hB5,1,0,1));
        vecs.push_back(mk(1,0,8'h00,0,8'h00, 1,0,0,8'hB5,1,0,1));
        vecs.push_back(mk(1,0,8'h00,0,8'h00, 1,1,0,8'hB5,1,0,1));
        vecs.push_back(mk(1,0,8'h00,0,8'h00, 1,1,0,8'hB5,1,1,1));
        vecs.push_back(mk(1,0,8'h00,0,8'h00, 1,1,0,8'hB5,1,1,1));
        vecs.push_back(mk(1,0,8'h00,0,8'h00, 1,1,0,8'hB5,1,1,1));
        vecs.push_back(mk(1,0,8'h00,0,8'h00, 0,0,0,8'hB5,1,1,1));
        vecs.push_back(mk(1,0,8'h00,0,8'h00, 0,0,0,8'hB5,1,1,1));
        vecs.push_back(mk(1,0,8'h00,0,8'h00, 0,0,0,8'hB5,0,1,1));
        // Burst extension: push during the only SEND cycle
        vecs.push_back(mk(1,1,8'h10,0,8'h00, 0,0,0,8'hB5,0,1,1));
        vecs.push_back(mk(1,0,8'h00,0,8'h00, 1,0,0,8'hB5,1,1,1));
        vecs.push_back(mk(1,0,8'h00,0,8'h00, 1,0,0,8'hB5,1,1,1));
        vecs.push_back(mk(1,1,8'h20,0,8'h00, 1,1,0,8'hB5,1,1,1));
        vecs.push_back(mk(1,0,8'h00,0,8'h00, 1,1,0,8'hB5,1,1,1));
        vecs.push_back(mk(1,0,8'h00,0,8'h00, 0,0,0,8'hB5,1,1,1));
        vecs.push_back(mk(1,0,8'h00,0,8'h00, 0,0,0,8'hB5,1,1,1));
        vecs.push_back(mk(1,0,8'h00,0,8'h00, 0,0,0,8'hB5,0,1,1));

        foreach (vecs[i]) begin
            apply(vecs[i], $sformatf("vec%0d", i));
        end

        // Reset asserted in SEND with two words still queued behind the head
        apply(mk(1,1,8'h30,0,8'h00, 0,0,0,8'hB5,0,1,1), "rst_send0");
        apply(mk(1,1,8'h31,0,8'h00, 1,0,0,8'hB5,1,1,1), "rst_send1");
        apply(mk(1,1,8'h32,0,8'h00, 1,0,0,8'hB5,1,1,1), "rst_send2");
        apply(mk(0,0,8'h00,0,8'h00, 1,1,0,8'hB5,1,1,1), "rst_send3");
        for (int k = 0; k < 5; k++) begin
            apply(mk(1,0,8'h00,0,8'h00, 0,0,0,8'h00,0,1,1), $sformatf("post_rst%0d", k));
        end

        n_checks++;
        if (exp_q.size() != 0) begin
            n_fail++;
            $display("FAIL scoreboard_drain: got %0d words pending, required 0", exp_q.size());
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
